// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I data-memory access stage: one req/ack bus transaction per load/store
// Steers byte lanes and write data by access size, extends load data, and stalls the core until retire.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        align_err_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  a_q, a_d;
    logic [2:0]  f3_q, f3_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] baddr_q, baddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ld_q, ld_d;
    logic        done_q, done_d;
    logic        aerr_q, aerr_d;
    logic        berr_q, berr_d;

    logic        access;
    logic        supported;
    logic        misaligned;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ext_c;

    assign access = mem_read_i | mem_write_i;

    // Request decode: size comes from funct3[1:0]; a store wins when both strobes are high.
    always_comb begin
        supported  = 1'b0;
        misaligned = 1'b0;
        be_c       = 4'b0000;
        wdata_c    = store_data_i;
        if (mem_write_i) begin
            supported = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
        end else begin
            supported = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                        (funct3_i == 3'b100) || (funct3_i == 3'b101);
        end
        case (funct3_i[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr_i[1:0];
                wdata_c = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                misaligned = addr_i[0];
                be_c       = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_c    = {2{store_data_i[15:0]}};
            end
            default: begin
                misaligned = (addr_i[1:0] != 2'b00);
                be_c       = 4'b1111;
            end
        endcase
    end

    // Load extraction uses the offset and width latched at issue.
    always_comb begin
        case (a_q)
            2'd0:    rbyte = bus_rdata_i[7:0];
            2'd1:    rbyte = bus_rdata_i[15:8];
            2'd2:    rbyte = bus_rdata_i[23:16];
            default: rbyte = bus_rdata_i[31:24];
        endcase
        rhalf = a_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        case (f3_q)
            3'b000:  ext_c = {{24{rbyte[7]}}, rbyte};
            3'b100:  ext_c = {24'h0, rbyte};
            3'b001:  ext_c = {{16{rhalf[15]}}, rhalf};
            3'b101:  ext_c = {16'h0, rhalf};
            default: ext_c = bus_rdata_i;
        endcase
        if (we_q) begin
            ext_c = 32'h0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        f3_d    = f3_q;
        req_d   = req_q;
        we_d    = we_q;
        baddr_d = baddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ld_d    = ld_q;
        done_d  = 1'b0;
        aerr_d  = 1'b0;
        berr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access) begin
                    a_d  = addr_i[1:0];
                    f3_d = funct3_i;
                    if (supported && !misaligned) begin
                        req_d   = 1'b1;
                        we_d    = mem_write_i;
                        baddr_d = {addr_i[31:2], 2'b00};
                        be_d    = be_c;
                        wdata_d = wdata_c;
                        cnt_d   = 8'd0;
                        state_d = REQ;
                    end else begin
                        ld_d    = 32'h0;
                        aerr_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                if (bus_ack_i) begin
                    ld_d    = ext_c;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else if (cnt_q == LAST_WAIT) begin
                    ld_d    = 32'h0;
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            a_q     <= 2'd0;
            f3_q    <= 3'd0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            baddr_q <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            ld_q    <= 32'h0;
            done_q  <= 1'b0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            f3_q    <= f3_d;
            req_q   <= req_d;
            we_q    <= we_d;
            baddr_q <= baddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ld_q    <= ld_d;
            done_q  <= done_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
        end
    end

    assign stall_o     = ((state_q == IDLE) && access && !rst_i) || (state_q == REQ);
    assign done_o      = done_q;
    assign load_data_o = ld_q;
    assign align_err_o = aerr_q;
    assign bus_err_o   = berr_q;
    assign bus_req_o   = req_q;
    assign bus_we_o    = we_q;
    assign bus_addr_o  = baddr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with directed vectors
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, store_data_i;
    logic        stall_o, done_o, align_err_o, bus_err_o;
    logic [31:0] load_data_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;
    logic        bus_ack_i;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
        .stall_o(stall_o), .done_o(done_o), .load_data_o(load_data_o),
        .align_err_o(align_err_o), .bus_err_o(bus_err_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ld;
        logic        aerr;
        logic        berr;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every done_o pulse is matched against the oldest expected response.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done_o), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("load_data", load_data_o, e.ld);
                    chk("align_err", 32'(align_err_o), 32'(e.aerr));
                    chk("bus_err", 32'(bus_err_o), 32'(e.berr));
                    chk("done_cycle", cyc, e.cyc);
                end
            end else if (align_err_o || bus_err_o) begin
                chk("err_without_done", {30'h0, align_err_o, bus_err_o}, 32'd0);
            end
        end
    end

    // waits: REQ cycles without ack before the ack cycle; -1 means never ack.
    task automatic run(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rdata,
                       input int waits, input logic exp_aerr, input logic [3:0] exp_be,
                       input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
        exp_t e;
        int   t0, nreq;
        @(posedge clk); #1;
        t0 = cyc;
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = addr; store_data_i = sd;
        e.ld   = exp_ld;
        e.aerr = exp_aerr;
        e.berr = !exp_aerr && (waits < 0);
        e.cyc  = exp_aerr ? t0 + 1 : (waits < 0 ? t0 + TO + 1 : t0 + 2 + waits);
        exp_q.push_back(e);
        #1 chk("stall_issue", 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        if (exp_aerr) begin
            chk("no_req_on_align_err", 32'(bus_req_o), 32'd0);
        end else begin
            nreq = (waits < 0) ? TO : waits + 1;
            for (int k = 0; k < nreq; k++) begin
                chk("bus_req", 32'(bus_req_o), 32'd1);
                chk("bus_we", 32'(bus_we_o), 32'(wr));
                chk("bus_addr", bus_addr_o, {addr[31:2], 2'b00});
                chk("bus_be", 32'(bus_be_o), 32'(exp_be));
                if (wr) chk("bus_wdata", bus_wdata_o, exp_wdata);
                chk("stall_req", 32'(stall_o), 32'd1);
                if (k == waits) begin
                    bus_ack_i = 1'b1; bus_rdata_i = rdata;
                end
                @(posedge clk); #1;
                bus_ack_i = 1'b0; bus_rdata_i = 32'hDEAD_BEEF;
            end
            chk("req_drop_in_done", 32'(bus_req_o), 32'd0);
            chk("stall_done", 32'(stall_o), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'b000;
        addr_i = 32'h0; store_data_i = 32'h0; bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_ld", load_data_o, 32'd0);
        rst_i = 1'b0;

        //   rd wr  f3      addr          sd            rdata         waits aerr be       wdata         ld
        run(1, 0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 4'b1000, 32'h0,        32'hFFFF_FF80);
        run(1, 0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 0, 4'b1000, 32'h0,        32'h0000_0080);
        run(0, 1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,        0, 0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        run(1, 0, 3'b101, 32'h0000_0202, 32'h0,        32'hBEEF_0000, 0, 0, 4'b1100, 32'h0,        32'h0000_BEEF);
        run(1, 0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0);
        run(1, 0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0);
        run(0, 1, 3'b010, 32'h0000_0400, 32'hCAFE_F00D, 32'h0,        3, 0, 4'b1111, 32'hCAFE_F00D, 32'h0);
        run(1, 0, 3'b010, 32'h0000_0500, 32'h0,        32'h0,        -1, 0, 4'b1111, 32'h0,        32'h0);
        run(1, 0, 3'b010, 32'h0000_0104, 32'h0,        32'h1234_5678, 0, 0, 4'b1111, 32'h0,        32'h1234_5678);
        run(1, 0, 3'b001, 32'h0000_0106, 32'h0,        32'h8001_7FFF, 1, 0, 4'b1100, 32'h0,        32'hFFFF_8001);
        run(1, 0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0, 0, 4'b0010, 32'h0,        32'h0000_007F);
        run(0, 1, 3'b000, 32'h0000_0003, 32'h0000_00A5, 32'h0,        0, 0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
        run(0, 1, 3'b100, 32'h0000_0010, 32'h1,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0);
        run(1, 0, 3'b001, 32'h0000_0201, 32'h0,        32'h0,         0, 1, 4'b0000, 32'h0,        32'h0);
        run(1, 0, 3'b010, 32'h0000_0108, 32'h0,        32'h0BAD_F00D, 0, 0, 4'b1111, 32'h0,        32'h0BAD_F00D);

        // Reset during the second REQ cycle, then a late ack that must be ignored.
        @(posedge clk); #1;
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0600;
        @(posedge clk); #1;
        mem_read_i = 1'b0;
        chk("rst_txn_req", 32'(bus_req_o), 32'd1);
        @(posedge clk); #1;
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h5555_5555;
        chk("rst_req_drop", 32'(bus_req_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'd0);
        chk("rst_be", 32'(bus_be_o), 32'd0);
        chk("rst_we", 32'(bus_we_o), 32'd0);
        chk("rst_wdata", bus_wdata_o, 32'd0);
        chk("rst_load_data", load_data_o, 32'd0);
        chk("rst_flags", {29'h0, done_o, align_err_o, bus_err_o}, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        chk("late_ack_no_done", 32'(done_o), 32'd0);
        chk("late_ack_no_req", 32'(bus_req_o), 32'd0);

        // Both strobes high: the store wins.
        run(1, 1, 3'b010, 32'h0000_0300, 32'h1234_5678, 32'hFFFF_FFFF, 0, 0, 4'b1111, 32'h1234_5678, 32'h0);

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage of the single-cycle RV32I core, directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data. It runs one request/acknowledge transaction on the data bus, with byte lanes and write data steered by access size. It returns sign- or zero-extended load data for write-back and stalls the core until the access retires.

## Interface
- TIMEOUT, 255: number of REQ cycles without `bus_ack_i` before the access is abandoned with a bus error.
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- mem_read_i  in  1  current instruction is a load.
- mem_write_i  in  1  current instruction is a store; wins if both are high (read ignored).
- funct3_i  in  3  width code.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other code is unsupported.
- addr_i  in  32  effective address (ALU result).
- store_data_i  in  32  rs2 value.
- stall_o  out  1  hold PC and register-file write while high.
- done_o  out  1  one-cycle pulse in the retiring cycle.
- load_data_o  out  32  extended load data; valid while done_o=1.
- align_err_o  out  1  pulse with done_o for a misaligned access or unsupported funct3.
- bus_err_o  out  1  pulse with done_o on timeout.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  1 = write.
- bus_addr_o  out  32  word address, {addr[31:2],2'b00}.
- bus_be_o  out  4  byte enables.
- bus_wdata_o  out  32  write data, lane-replicated.
- bus_rdata_i  in  32  read data, sampled on ack.
- bus_ack_i  in  1  transfer complete.

## Operation
- FSM states: IDLE, REQ, DONE.
- **IDLE**
  - Transition: with (mem_read_i | mem_write_i), latch addr_i[1:0], funct3_i and direction.
    - Aligned and supported: load bus_addr_o, bus_be_o, bus_wdata_o and bus_we_o, and go to REQ.
    - Otherwise: go to DONE with the align error flagged; the bus is never requested.
  - bus_ack_i is ignored in IDLE.
- **Alignment rules**
  - Halfword: requires addr[0]=0.
  - Word: requires addr[1:0]=00.
  - Byte: never misaligned.
- **Byte enables**
  - Byte access: 4'b0001 << addr[1:0].
  - Halfword access: 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - Word access: 1111.
  - Loads drive the same enables.
- **Write data**
  - SB: {4{sd[7:0]}}.
  - SH: {2{sd[15:0]}}.
  - SW: sd.
- **REQ**
  - bus_req_o=1; all bus outputs stay stable until ack.
  - On bus_ack_i: capture the extracted and extended bus_rdata_i into load_data_o (stores write 0), then go to DONE.
  - An 8-bit wait counter counts REQ cycles. If the counter reaches TIMEOUT without ack: load_data_o=0, bus_err_o is flagged, go to DONE.
- **Load extraction**
  - Byte: b = rdata[8*a+7 : 8*a], where a = addr[1:0].
    - LB sign-extends b[7]; LBU zero-extends.
  - Halfword: h = rdata[16*addr[1]+15 : 16*addr[1]].
    - LH sign-extends; LHU zero-extends.
  - LW passes rdata unchanged.
- **DONE**
  - done_o=1, stall_o=0, bus_req_o=0.
  - align_err_o / bus_err_o are high if flagged.
  - Unconditionally return to IDLE. The core advances on this edge, so the same instruction is never re-issued.
- **stall_o** (combinational): (IDLE & (mem_read_i | mem_write_i) & ~rst_i) | REQ.
- **Reset**
  - Any state goes to IDLE on the next edge.
  - All registered outputs clear to 0: bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, load_data_o, done_o, align_err_o, bus_err_o.
  - A transaction in flight is abandoned; bus_req_o drops at that edge, and a late ack is ignored.

## Timing
- Normal access with ack in the first REQ cycle: minimum 3 cycles.
  - Cycle 0: IDLE, stall.
  - Cycle 1: REQ, ack.
  - Cycle 2: DONE.
- Each wait cycle without ack adds one cycle.
- Misaligned or unsupported access: 2 cycles (IDLE, DONE); bus_req_o is never asserted.
- Timeout: DONE follows the TIMEOUT-th REQ cycle, giving TIMEOUT+2 cycles total.
- done_o, load_data_o and the error flags are registered; load_data_o holds its value until the next DONE or reset.
- bus_* outputs are registered and change only on the IDLE→REQ edge or the REQ→DONE edge.

## Test plan
- LB at 0x0000_0103, rdata 0x80FF_1234 → bus_addr_o 0x100, bus_be_o 1000, load_data_o 0xFFFF_FF80; LBU same access → 0x0000_0080; done_o on cycle 2.
- SH to 0x0000_0202, store_data 0x0000_BEEF → bus_addr_o 0x200, bus_we_o 1, bus_be_o 1100, bus_wdata_o 0xBEEF_BEEF; LHU at 0x202 with rdata 0xBEEF_0000 → 0x0000_BEEF.
- LW at 0x101 → bus_req_o never high, align_err_o and done_o high on cycle 1, load_data_o 0; funct3 011 load gives the same response.
- SW with ack delayed 3 cycles → stall_o high cycles 0–4, bus outputs constant through REQ, done_o on cycle 5.
- TIMEOUT=4, LW with no ack → 4 REQ cycles, then bus_err_o and done_o; load_data_o 0; next instruction proceeds normally.
- rst_i asserted during the 2nd REQ cycle → bus_req_o 0 and all outputs 0 next cycle; ack arriving the following cycle → no done_o; mem_read_i and mem_write_i both high → store performed.
